// File: rtl/sa_pkg.sv
// Shared definitions for the 3x3 weight-stationary array output path.
//  - DATA_W : default width of one psum column
//  - N_COLS : number of array columns collected per result row
//  - coll_state_t : collector FSM state encoding
//  - col_lsb() : bit position of a column inside a packed result row
//    (column 1 sits in the LSBs, column 3 in the MSBs)
package sa_pkg;

  localparam int DATA_W = 8;
  localparam int N_COLS = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_CAPT = 2'd2,
    ST_DONE = 2'd3
  } coll_state_t;

  // Row packing order: {col3, col2, col1}; col is 0-based (0 = col1).
  function automatic int col_lsb(input int col, input int width);
    return col * width;
  endfunction

endpackage

// File: rtl/sa_result_fifo.sv
// Synchronous result FIFO for aligned psum rows.
// Ports:
//  clk, rst   clock, asynchronous active-high reset
//  clear      synchronous flush (wins over push/pop)
//  push/wdata write a row; ignored when full unless a pop happens the same edge
//  pop        remove the head; ignored when empty
//  rdata      head row (0 when empty)
//  empty      no rows stored
//  count      number of rows stored (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module sa_result_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             full, do_push, do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty & ~clear;
  // A push into a full FIFO still lands when the head leaves on the same edge.
  assign do_push = push & (~full | do_pop) & ~clear;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Gate the head so nothing stale is visible while empty.
  assign rdata = empty ? '0 : mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/sa3x3_out_collector.sv
// Output collector for the 3x3 weight-stationary array.
// Samples the three staggered psum columns, removes the 0/1/2-cycle column
// skew and queues one aligned {col3,col2,col1} row per input vector.
// Ports:
//  clk, rst              clock, asynchronous active-high reset
//  clear                 synchronous flush of FIFO, FSM and overflow flag
//  start, num_vec        batch start pulse and vector count (0 = no capture)
//  psum_in1..3           array column outputs (col2 +1, col3 +2 cycles late)
//  res_valid/ready/data  result FIFO head handshake
//  busy, done, overflow  FSM not idle, end-of-batch pulse, sticky drop flag
// Optional feature: define SA_COLLECT_RELU_EN to clamp negative (signed)
// column values to zero before they enter the FIFO.
module sa3x3_out_collector
  import sa_pkg::*;
#(
  parameter int DATA_W  = sa_pkg::DATA_W,
  parameter int LATENCY = 3,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     start,
  input  logic [CNT_W-1:0]         num_vec,
  input  logic [DATA_W-1:0]        psum_in1,
  input  logic [DATA_W-1:0]        psum_in2,
  input  logic [DATA_W-1:0]        psum_in3,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [N_COLS*DATA_W-1:0] res_data,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow
);

  localparam int ROW_W  = N_COLS * DATA_W;
  localparam int WAIT_W = $clog2(LATENCY + 2);
  localparam int AW     = $clog2(DEPTH);

  // ---------------- deskew ----------------
  logic [N_COLS-1:0][DATA_W-1:0] col_in, col_aligned;
  logic [ROW_W-1:0]              row_word;

  assign col_in[0] = psum_in1;
  assign col_in[1] = psum_in2;
  assign col_in[2] = psum_in3;

  // Column gi arrives gi cycles late, so it needs (N_COLS-1-gi) delay stages
  // for all columns of one vector to line up with the last column.
  for (genvar gi = 0; gi < N_COLS; gi++) begin : g_col
    localparam int DLY = N_COLS - 1 - gi;
    if (DLY == 0) begin : g_direct
      assign col_aligned[gi] = col_in[gi];
    end else begin : g_pipe
      logic [DLY-1:0][DATA_W-1:0] pipe_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pipe_reg <= '0;
        end else begin
          pipe_reg[0] <= col_in[gi];
          for (int i = 1; i < DLY; i++) pipe_reg[i] <= pipe_reg[i-1];
        end
      end
      assign col_aligned[gi] = pipe_reg[DLY-1];
    end
`ifdef SA_COLLECT_RELU_EN
    assign row_word[col_lsb(gi, DATA_W) +: DATA_W] =
      col_aligned[gi][DATA_W-1] ? '0 : col_aligned[gi];
`else
    assign row_word[col_lsb(gi, DATA_W) +: DATA_W] = col_aligned[gi];
`endif
  end

  // ---------------- FSM ----------------
  coll_state_t         state_reg, state_next;
  logic [WAIT_W-1:0]   wait_cnt_reg, wait_cnt_next;
  logic [CNT_W-1:0]    row_cnt_reg, row_cnt_next;
  logic                capt_push;
  logic                overflow_reg;
  logic                fifo_empty, fifo_full, pop;
  logic [AW:0]         fifo_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      wait_cnt_reg <= '0;
      row_cnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      row_cnt_reg  <= row_cnt_next;
    end
  end

  // WAIT is loaded with LATENCY and leaves on zero, i.e. LATENCY+1 cycles,
  // so the first CAPT push lands on edge start+LATENCY+2 when col3 of
  // vector 0 is on psum_in3.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    row_cnt_next  = row_cnt_reg;
    capt_push     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (num_vec != '0) begin
            state_next    = ST_WAIT;
            wait_cnt_next = WAIT_W'(LATENCY);
            row_cnt_next  = num_vec;
          end else begin
            state_next = ST_DONE;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt_reg == '0) state_next = ST_CAPT;
        else                    wait_cnt_next = wait_cnt_reg - WAIT_W'(1);
      end
      ST_CAPT: begin
        capt_push    = 1'b1;
        row_cnt_next = row_cnt_reg - CNT_W'(1);
        if (row_cnt_reg == CNT_W'(1)) state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (clear) begin
      state_next = ST_IDLE;
      capt_push  = 1'b0;
    end
  end

  // ---------------- result FIFO + overflow ----------------
  assign fifo_full = (fifo_count == (AW+1)'(DEPTH));
  assign res_valid = ~fifo_empty;
  assign pop       = res_valid & res_ready;

  sa_result_fifo #(
    .WIDTH (ROW_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (capt_push),
    .wdata (row_word),
    .pop   (pop),
    .rdata (res_data),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // The array cannot be stalled: a row meeting a full FIFO with no pop is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       overflow_reg <= 1'b0;
    else if (clear)                                overflow_reg <= 1'b0;
    else if (capt_push && fifo_full && !pop)       overflow_reg <= 1'b1;
  end

  assign overflow = overflow_reg;
  assign busy     = (state_reg != ST_IDLE);
  assign done     = (state_reg == ST_DONE);

endmodule

// File: tb/tb_sa3x3_out_collector.sv
`timescale 1ns/1ps
module tb_sa3x3_out_collector;

  localparam int DATA_W  = 8;
  localparam int LATENCY = 3;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 8;
  localparam int ROW_W   = 3 * DATA_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clear = 1'b0;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  num_vec = '0;
  logic [DATA_W-1:0] psum_in1 = '0, psum_in2 = '0, psum_in3 = '0;
  logic              res_ready = 1'b0;
  logic              res_valid, busy, done, overflow;
  logic [ROW_W-1:0]  res_data;

  sa3x3_out_collector #(
    .DATA_W (DATA_W), .LATENCY (LATENCY), .DEPTH (DEPTH), .CNT_W (CNT_W)
  ) dut (
    .clk (clk), .rst (rst), .clear (clear), .start (start), .num_vec (num_vec),
    .psum_in1 (psum_in1), .psum_in2 (psum_in2), .psum_in3 (psum_in3),
    .res_valid (res_valid), .res_ready (res_ready), .res_data (res_data),
    .busy (busy), .done (done), .overflow (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Per-vector column values of the current batch (driven onto the skewed inputs).
  logic [DATA_W-1:0] vec1 [16];
  logic [DATA_W-1:0] vec2 [16];
  logic [DATA_W-1:0] vec3 [16];

  // ---------------- behavioural model ----------------
  logic [ROW_W-1:0] exp_q [$];
  bit exp_busy = 0, exp_done = 0, exp_ovf = 0;
  bit b_valid = 0;
  int b_e0 = 0, b_n = 0, cap_start = 0, busy_end = 0, done_edge = 0;
  int edge_n = 0;

  function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] v);
`ifdef SA_COLLECT_RELU_EN
    return ($signed(v) < 0) ? '0 : v;
`else
    return v;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Timeline model: a batch accepted at edge E0 pushes row k at edge
  // E0+LATENCY+2+k, reports done right after its last push, idles one edge later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      exp_busy = 0; exp_done = 0; exp_ovf = 0; b_valid = 0;
    end else begin : step
      bit pop;
      int k;
      edge_n++;
      if (clear) begin
        exp_q.delete();
        exp_ovf = 0;
        b_valid = 0;
      end else begin
        pop = (exp_q.size() > 0) && res_ready;
        if (start && !exp_busy) begin
          b_valid   = 1;
          b_e0      = edge_n;
          b_n       = int'(num_vec);
          cap_start = edge_n + LATENCY + 2;
          busy_end  = (b_n == 0) ? edge_n + 1 : cap_start + b_n;
          done_edge = busy_end - 1;
        end
        if (pop) void'(exp_q.pop_front());
        if (b_valid && b_n > 0 && edge_n >= cap_start && edge_n < cap_start + b_n) begin
          k = edge_n - cap_start;
          if (exp_q.size() < DEPTH) exp_q.push_back({relu(vec3[k]), relu(vec2[k]), relu(vec1[k])});
          else exp_ovf = 1;
        end
      end
      exp_busy = b_valid && (edge_n < busy_end);
      exp_done = b_valid && (edge_n == done_edge);
    end
  end

  // Compare process: every cycle, mid-cycle.
  always @(negedge clk) begin
    check("res_valid", 32'(res_valid), 32'(exp_q.size() > 0));
    if (res_valid && exp_q.size() > 0) check("res_data", 32'(res_data), 32'(exp_q[0]));
    check("busy", 32'(busy), 32'(exp_busy));
    check("done", 32'(done), 32'(exp_done));
    check("overflow", 32'(overflow), 32'(exp_ovf));
  end

  // ---------------- stimulus ----------------
  // Column c of vector k is sampled at edge E0+LATENCY+c+k; anything else is noise.
  task automatic drive_psums();
    int m, k;
    m = edge_n + 1;
    psum_in1 = DATA_W'($urandom);
    psum_in2 = DATA_W'($urandom);
    psum_in3 = DATA_W'($urandom);
    if (b_valid) begin
      k = m - (b_e0 + LATENCY);
      if (k >= 0 && k < b_n) psum_in1 = vec1[k];
      k = m - (b_e0 + LATENCY + 1);
      if (k >= 0 && k < b_n) psum_in2 = vec2[k];
      k = m - (b_e0 + LATENCY + 2);
      if (k >= 0 && k < b_n) psum_in3 = vec3[k];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive_psums();
  endtask

  task automatic fill_vecs();
    for (int i = 0; i < 16; i++) begin
      vec1[i] = DATA_W'($urandom);
      vec2[i] = DATA_W'($urandom);
      vec3[i] = DATA_W'($urandom);
    end
  endtask

  task automatic start_batch(input int n);
    start = 1'b1; num_vec = CNT_W'(n);
    tick();
    start = 1'b0; num_vec = '0;
  endtask

  initial begin
    fill_vecs();
    repeat (3) tick();
    check("reset_valid", 32'(res_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // Async reset in the middle of WAIT with rows already queued.
    res_ready = 1'b0;
    start_batch(2);
    repeat (8) tick();
    check("pre_reset_valid", 32'(res_valid), 32'd1);
    start_batch(3);
    tick();
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(res_valid), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_ovf", 32'(overflow), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    tick();

    // Skew removal: one vector 5/6/7.
    vec1[0] = 8'h05; vec2[0] = 8'h06; vec3[0] = 8'h07;
    start_batch(1);
    repeat (5) tick();
    check("skew_data", 32'(res_data), 32'h070605);
    check("skew_done", 32'(done), 32'd1);
    tick();
    check("skew_busy_low", 32'(busy), 32'd0);
    res_ready = 1'b1;
    tick();
    check("skew_popped", 32'(res_valid), 32'd0);

    // Streaming four rows with the sink always ready.
    fill_vecs();
    start_batch(4);
    repeat (12) tick();
    check("stream_no_ovf", 32'(overflow), 32'd0);

    // Backpressure: six rows into a four-deep FIFO.
    fill_vecs();
    res_ready = 1'b0;
    start_batch(6);
    repeat (12) tick();
    check("bp_ovf", 32'(overflow), 32'd1);
    res_ready = 1'b1;
    repeat (6) tick();
    check("bp_drained", 32'(res_valid), 32'd0);
    clear = 1'b1; tick(); clear = 1'b0;
    check("clear_ovf", 32'(overflow), 32'd0);

    // Start while busy is ignored; num_vec=0 finishes immediately.
    fill_vecs();
    start_batch(3);
    start = 1'b1; num_vec = '0;
    repeat (2) tick();
    start = 1'b0;
    repeat (10) tick();
    start_batch(0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_valid", 32'(res_valid), 32'd0);
    tick();
    check("zero_idle", 32'(busy), 32'd0);

    // Clear in the middle of CAPT.
    fill_vecs();
    res_ready = 1'b0;
    start_batch(8);
    repeat (7) tick();
    check("capt_busy", 32'(busy), 32'd1);
    clear = 1'b1; tick(); clear = 1'b0;
    check("clear_capt_busy", 32'(busy), 32'd0);
    check("clear_capt_valid", 32'(res_valid), 32'd0);
    repeat (10) tick();

    // Signed row {0x80,0x01,0xFF}.
    vec1[0] = 8'hFF; vec2[0] = 8'h01; vec3[0] = 8'h80;
    start_batch(1);
    repeat (5) tick();
`ifdef SA_COLLECT_RELU_EN
    check("relu_row", 32'(res_data), 32'h000100);
`else
    check("raw_row", 32'(res_data), 32'h8001FF);
`endif
    res_ready = 1'b1;
    repeat (2) tick();

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      res_ready = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 59) == 0);
      start     = 1'b0;
      if (!exp_busy && $urandom_range(0, 2) == 0) begin
        fill_vecs();
        start   = 1'b1;
        num_vec = CNT_W'($urandom_range(0, 9));
      end else if ($urandom_range(0, 15) == 0) begin
        start   = 1'b1;
        num_vec = CNT_W'($urandom_range(0, 9));
      end
      tick();
    end
    start = 1'b0; clear = 1'b0; res_ready = 1'b1;
    repeat (20) tick();
    check("final_empty", 32'(res_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
